// File: rtl/io_out_fifo_if.sv
// CPU-write / device-drain bundle for io_out_fifo: write strobe side, status, and show-ahead valid/ready side.
interface io_out_fifo_if #(
   parameter int WIDTH      = 8,
   parameter int PORT_W     = 2,
   parameter int DEPTH_LOG2 = 2
);
   logic                  we;
   logic [PORT_W-1:0]     wa;
   logic [WIDTH-1:0]      wd;
   logic                  full;
   logic                  empty;
   logic [DEPTH_LOG2:0]   count;
   logic                  out_valid;
   logic [PORT_W-1:0]     out_port;
   logic [WIDTH-1:0]      out_data;
   logic                  out_ready;

   modport slave (
      input  we, wa, wd, out_ready,
      output full, empty, count, out_valid, out_port, out_data
   );

   modport master (
      output we, wa, wd, out_ready,
      input  full, empty, count, out_valid, out_port, out_data
   );
endinterface

// File: rtl/io_out_fifo.sv
// Show-ahead output FIFO between the single-cycle CPU and slow peripherals; write visible next cycle, drained by valid/ready,
// writes to a full FIFO without a same-cycle pop are dropped (flagged on ovf when IO_OUT_FIFO_OVF_EN is defined).
module io_out_fifo #(
   parameter int WIDTH      = 8,
   parameter int PORT_W     = 2,
   parameter int DEPTH_LOG2 = 2
) (
   input  logic           clk,
   input  logic           reset,
   io_out_fifo_if.slave   bus
`ifdef IO_OUT_FIFO_OVF_EN
   ,
   input  logic           ovf_clr,
   output logic           ovf
`endif
);

   localparam int                  DEPTH    = 1 << DEPTH_LOG2;
   localparam logic [DEPTH_LOG2:0] FULL_CNT = DEPTH[DEPTH_LOG2:0];

   typedef struct packed {
      logic [PORT_W-1:0] port;
      logic [WIDTH-1:0]  data;
   } entry_t;

   entry_t                mem [DEPTH];
   entry_t                head;
   logic [DEPTH_LOG2-1:0] wr_ptr;
   logic [DEPTH_LOG2-1:0] rd_ptr;
   logic [DEPTH_LOG2:0]   cnt;
   logic                  full;
   logic                  empty;
   logic                  push;
   logic                  pop;

   assign full  = (cnt == FULL_CNT);
   assign empty = (cnt == '0);
   assign pop   = !empty && bus.out_ready;
   // A full FIFO still accepts a write when the head leaves on the same edge.
   assign push  = bus.we && (!full || pop);

   assign head          = mem[rd_ptr];
   assign bus.full      = full;
   assign bus.empty     = empty;
   assign bus.count     = cnt;
   assign bus.out_valid = !empty;
   assign bus.out_port  = empty ? '0 : head.port;
   assign bus.out_data  = empty ? '0 : head.data;

   // Storage is deliberately left uninitialised; the counter gates visibility.
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= '{port: bus.wa, data: bus.wd};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({push, pop})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end

`ifdef IO_OUT_FIFO_OVF_EN
   // Sticky drop flag; a drop on the same edge as a clear keeps it set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         ovf <= 1'b0;
      end else if (bus.we && full && !pop) begin
         ovf <= 1'b1;
      end else if (ovf_clr) begin
         ovf <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_io_out_fifo.sv
// Directed bench for io_out_fifo: a scoreboard queue is filled at issue time and drained by a negedge monitor.
module tb_io_out_fifo;
   logic clk;
   logic reset;
   int   checks;
   int   errors;
   int   model_cnt;
   logic [9:0] sb [$];

   io_out_fifo_if #(.WIDTH(8), .PORT_W(2), .DEPTH_LOG2(2)) bus ();

`ifdef IO_OUT_FIFO_OVF_EN
   logic ovf_clr;
   logic ovf;
`endif

   io_out_fifo #(.WIDTH(8), .PORT_W(2), .DEPTH_LOG2(2)) dut (
      .clk     (clk),
      .reset   (reset),
      .bus     (bus)
`ifdef IO_OUT_FIFO_OVF_EN
      ,
      .ovf_clr (ovf_clr),
      .ovf     (ovf)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Monitor: every accepted head entry is compared against the oldest expected entry.
   always @(negedge clk) begin
      if (!reset && bus.out_valid && bus.out_ready) begin
         if (sb.size() == 0) begin
            chk("unexpected_entry", {22'd0, bus.out_port, bus.out_data}, 32'hFFFF_FFFF);
         end else begin
            logic [9:0] e;
            e = sb.pop_front();
            chk("head_port", {30'd0, bus.out_port}, {30'd0, e[9:8]});
            chk("head_data", {24'd0, bus.out_data}, {24'd0, e[7:0]});
         end
      end
   end

   // Called just after a posedge; drives one cycle of stimulus and returns just after the next posedge.
   task automatic cycle(input logic w, input logic [1:0] a, input logic [7:0] d, input logic r, input logic clr);
      logic p_pop;
      logic p_push;
      p_pop  = (model_cnt != 0) && r;
      p_push = w && ((model_cnt < 4) || p_pop);
      if (p_push) sb.push_back({a, d});
      model_cnt = model_cnt + int'(p_push) - int'(p_pop);
      bus.we        = w;
      bus.wa        = a;
      bus.wd        = d;
      bus.out_ready = r;
`ifdef IO_OUT_FIFO_OVF_EN
      ovf_clr = clr;
`endif
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input logic r);
      cycle(1'b0, 2'd0, 8'h00, r, 1'b0);
   endtask

   initial begin
      checks        = 0;
      errors        = 0;
      model_cnt     = 0;
      reset         = 1'b1;
      bus.we        = 1'b0;
      bus.wa        = '0;
      bus.wd        = '0;
      bus.out_ready = 1'b0;
`ifdef IO_OUT_FIFO_OVF_EN
      ovf_clr = 1'b0;
`endif
      #2;
      chk("rst_count", {29'd0, bus.count}, 32'd0);
      chk("rst_empty", {31'd0, bus.empty}, 32'd1);
      chk("rst_full",  {31'd0, bus.full},  32'd0);
      chk("rst_valid", {31'd0, bus.out_valid}, 32'd0);
`ifdef IO_OUT_FIFO_OVF_EN
      chk("rst_ovf", {31'd0, ovf}, 32'd0);
`endif
      @(posedge clk); #1;
      reset = 1'b0;

      // Asynchronous reset with entries buffered.
      cycle(1'b1, 2'd1, 8'h3C, 1'b0, 1'b0);
      cycle(1'b1, 2'd1, 8'h3D, 1'b0, 1'b0);
      chk("pre_rst_count", {29'd0, bus.count}, 32'd2);
      #2 reset = 1'b1;
      #1;
      chk("async_count", {29'd0, bus.count}, 32'd0);
      chk("async_empty", {31'd0, bus.empty}, 32'd1);
      chk("async_full",  {31'd0, bus.full},  32'd0);
      chk("async_valid", {31'd0, bus.out_valid}, 32'd0);
      chk("async_data",  {24'd0, bus.out_data}, 32'd0);
      chk("async_port",  {30'd0, bus.out_port}, 32'd0);
      sb.delete();
      model_cnt = 0;
      @(posedge clk); #1;
      reset = 1'b0;

      // Single write, held under backpressure.
      cycle(1'b1, 2'd2, 8'hA5, 1'b0, 1'b0);
      chk("t2_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("t2_port",  {30'd0, bus.out_port}, 32'd2);
      chk("t2_data",  {24'd0, bus.out_data}, 32'hA5);
      for (int i = 0; i < 3; i++) begin
         idle(1'b0);
         chk("t2_hold_data",  {24'd0, bus.out_data}, 32'hA5);
         chk("t2_hold_count", {29'd0, bus.count}, 32'd1);
      end
      idle(1'b1);
      chk("t2_empty", {31'd0, bus.empty}, 32'd1);

      // Fill to full, then drain in order.
      for (int i = 1; i <= 4; i++) cycle(1'b1, 2'(i), 8'(i), 1'b0, 1'b0);
      chk("t3_full",  {31'd0, bus.full}, 32'd1);
      chk("t3_count", {29'd0, bus.count}, 32'd4);
      for (int i = 0; i < 4; i++) idle(1'b1);
      chk("t3_empty", {31'd0, bus.empty}, 32'd1);

      // Full with simultaneous push and pop, wrapping the pointers.
      for (int i = 0; i < 4; i++) cycle(1'b1, 2'd0, 8'hA0 + 8'(i), 1'b0, 1'b0);
      for (int i = 0; i < 6; i++) begin
         cycle(1'b1, 2'd3, 8'h50 + 8'(i), 1'b1, 1'b0);
         chk("t4_count", {29'd0, bus.count}, 32'd4);
      end
      chk("t4_head", {24'd0, bus.out_data}, 32'h52);
      for (int i = 0; i < 4; i++) idle(1'b1);
      chk("t4_empty", {31'd0, bus.empty}, 32'd1);

      // Full with backpressure: the write is dropped.
      for (int i = 0; i < 4; i++) cycle(1'b1, 2'd1, 8'hC0 + 8'(i), 1'b0, 1'b0);
      cycle(1'b1, 2'd3, 8'hEE, 1'b0, 1'b0);
      chk("t5_count", {29'd0, bus.count}, 32'd4);
      chk("t5_head",  {24'd0, bus.out_data}, 32'hC0);
`ifdef IO_OUT_FIFO_OVF_EN
      chk("t5_ovf_set", {31'd0, ovf}, 32'd1);
      idle(1'b0);
      chk("t5_ovf_sticky", {31'd0, ovf}, 32'd1);
      cycle(1'b0, 2'd0, 8'h00, 1'b0, 1'b1);
      chk("t5_ovf_clr", {31'd0, ovf}, 32'd0);
`endif
      for (int i = 0; i < 4; i++) idle(1'b1);
      chk("t5_empty", {31'd0, bus.empty}, 32'd1);

      // Empty with write and ready together: no pop on that edge.
      cycle(1'b1, 2'd2, 8'h77, 1'b1, 1'b0);
      chk("t6_count", {29'd0, bus.count}, 32'd1);
      chk("t6_data",  {24'd0, bus.out_data}, 32'h77);
      idle(1'b1);
      chk("t6_drained", {29'd0, bus.count}, 32'd0);

      idle(1'b0);
      chk("sb_leftover", sb.size(), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
